// File: rtl/atm_pkg.sv
// Shared ATM definitions: keyboard ASCII codes, field modes and system clock rate.
package atm_pkg;

    localparam int unsigned CLOCK_FREQ = 100_000_000;

    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_BS    = 8'h08;
    localparam logic [7:0] KEY_QUIT  = 8'h71;
    localparam logic [7:0] KEY_MASK  = 8'h2A;
    localparam logic [7:0] KEY_0     = 8'h30;
    localparam logic [7:0] KEY_9     = 8'h39;

    typedef enum logic {
        FIELD_NUMERIC = 1'b0,
        FIELD_SELECT  = 1'b1
    } field_mode_e;

    function automatic logic is_digit(logic [7:0] code);
        return (code >= KEY_0) && (code <= KEY_9);
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Inactivity counter: counts while enabled, restarts on clear, pulses expire at TIMEOUT_CYCLES-1.
module inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 300000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LastCount = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // A clear in the expiry cycle suppresses the pulse.
    always_comb begin
        expire = enable && !clear && (cnt_q == LastCount);
        cnt_d  = cnt_q + 1'b1;
        if (!enable || clear || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_field_capture.sv
// Collects a BCD numeric field or single-key selection from the ASCII key stream.
// Define KEYPAD_TIMEOUT_EN to include the inactivity timeout.
module keypad_field_capture
    import atm_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned MIN_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 300000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         mask,
    input  logic                         key_valid,
    input  logic [7:0]                   key_code,
    output logic [4*DIGITS-1:0]          value,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         busy,
    output logic                         done,
    output logic                         reject,
    output logic                         cancel,
    output logic                         timeout,
    output logic                         echo_valid,
    output logic [7:0]                   echo_code
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned VW = 4 * DIGITS;
    localparam logic [CW-1:0] MaxCount = CW'(DIGITS);
    localparam logic [CW-1:0] MinCount = CW'(MIN_DIGITS);

    typedef enum logic {
        StIdle,
        StCollect
    } state_e;

    state_e          state_q, state_d;
    field_mode_e     mode_q, mode_d;
    logic            mask_q, mask_d;
    logic [VW-1:0]   value_q, value_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q, done_d, reject_q, reject_d, cancel_q, cancel_d;
    logic            timeout_q, timeout_d, echo_valid_q, echo_valid_d;
    logic [7:0]      echo_code_q, echo_code_d;
    logic            expire;
    logic            accept;

`ifdef KEYPAD_TIMEOUT_EN
    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (key_valid),
        .enable(state_q == StCollect),
        .expire(expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        mask_d       = mask_q;
        value_d      = value_q;
        count_d      = count_q;
        done_d       = 1'b0;
        reject_d     = 1'b0;
        cancel_d     = 1'b0;
        timeout_d    = 1'b0;
        echo_valid_d = 1'b0;
        echo_code_d  = echo_code_q;
        accept       = (mode_q == FIELD_SELECT) ? (count_q == CW'(1)) : (count_q >= MinCount);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                    mode_d  = field_mode_e'(mode);
                    mask_d  = mask;
                    value_d = '0;
                    count_d = '0;
                end
            end
            StCollect: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (mode_q == FIELD_SELECT || count_q < MaxCount) begin
                            echo_valid_d = 1'b1;
                            echo_code_d  = mask_q ? KEY_MASK : key_code;
                            if (mode_q == FIELD_SELECT) begin
                                value_d = VW'(key_code[3:0]);
                                count_d = CW'(1);
                            end else begin
                                value_d = (value_q << 4) | VW'(key_code[3:0]);
                                count_d = count_q + 1'b1;
                            end
                        end
                    end else if (key_code == KEY_BS) begin
                        if (count_q != '0) begin
                            value_d = value_q >> 4;
                            count_d = count_q - 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (accept) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (key_code == KEY_QUIT) begin
                        cancel_d = 1'b1;
                        state_d  = StIdle;
                        value_d  = '0;
                        count_d  = '0;
                    end
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                    value_d   = '0;
                    count_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mode_q       <= FIELD_NUMERIC;
            mask_q       <= 1'b0;
            value_q      <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            reject_q     <= 1'b0;
            cancel_q     <= 1'b0;
            timeout_q    <= 1'b0;
            echo_valid_q <= 1'b0;
            echo_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            count_q      <= count_d;
            done_q       <= done_d;
            reject_q     <= reject_d;
            cancel_q     <= cancel_d;
            timeout_q    <= timeout_d;
            echo_valid_q <= echo_valid_d;
            echo_code_q  <= echo_code_d;
        end
    end

    assign value      = value_q;
    assign count      = count_q;
    assign busy       = (state_q == StCollect);
    assign done       = done_q;
    assign reject     = reject_q;
    assign cancel     = cancel_q;
    assign timeout    = timeout_q;
    assign echo_valid = echo_valid_q;
    assign echo_code  = echo_code_q;

endmodule

// File: tb/tb_keypad_field_capture.sv
// Directed bench for keypad_field_capture with a strobe/echo scoreboard.
module tb_keypad_field_capture;

    localparam int unsigned DIGITS = 4;

    // Strobe vector bit order: {echo_valid, timeout, cancel, reject, done}
    localparam logic [4:0] S_NONE   = 5'b00000;
    localparam logic [4:0] S_DONE   = 5'b00001;
    localparam logic [4:0] S_REJECT = 5'b00010;
    localparam logic [4:0] S_CANCEL = 5'b00100;
    localparam logic [4:0] S_TMO    = 5'b01000;
    localparam logic [4:0] S_ECHO   = 5'b10000;

    typedef struct {
        string      tag;
        logic [4:0] strobes;
        logic [7:0] echo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        mask = 1'b0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [15:0] value;
    logic [2:0]  count;
    logic        busy, done, reject, cancel, timeout, echo_valid;
    logic [7:0]  echo_code;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    keypad_field_capture #(
        .DIGITS        (DIGITS),
        .MIN_DIGITS    (4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .mask      (mask),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .reject    (reject),
        .cancel    (cancel),
        .timeout   (timeout),
        .echo_valid(echo_valid),
        .echo_code (echo_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock; scoreboard pops an expectation whenever any strobe fires.
    task automatic tick();
        logic [4:0] strb;
        exp_t       e;
        @(posedge clk);
        #1;
        strb = {echo_valid, timeout, cancel, reject, done};
        if (strb != S_NONE) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'(strb), 32'(S_NONE));
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_strobe"}, 32'(strb), 32'(e.strobes));
                if (e.strobes[4]) chk({e.tag, "_echo"}, 32'(echo_code), 32'(e.echo));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic begin_field(input string tag, input logic m, input logic k);
        start = 1'b1;
        mode  = m;
        mask  = k;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_value"}, 32'(value), 32'd0);
    endtask

    task automatic press(input string tag, input logic [7:0] code, input logic [4:0] strb,
                         input logic [7:0] echo, input logic [15:0] val, input logic [2:0] cnt);
        exp_t e;
        e.tag = tag;
        e.strobes = strb;
        e.echo = echo;
        if (strb != S_NONE) exp_q.push_back(e);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 8'h00;
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_value"}, 32'(value), 32'(val));
        chk({tag, "_count"}, 32'(count), 32'(cnt));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_value"}, 32'(value), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_flags"}, 32'({busy, done, reject, cancel, timeout, echo_valid}), 32'd0);
        chk({tag, "_echo_code"}, 32'(echo_code), 32'd0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Numeric entry, unmasked echo
        begin_field("num", 1'b0, 1'b0);
        press("num_1", 8'h31, S_ECHO, 8'h31, 16'h0001, 3'd1);
        press("num_2", 8'h32, S_ECHO, 8'h32, 16'h0012, 3'd2);
        press("num_3", 8'h33, S_ECHO, 8'h33, 16'h0123, 3'd3);
        press("num_4", 8'h34, S_ECHO, 8'h34, 16'h1234, 3'd4);
        press("num_enter", 8'h0D, S_DONE, 8'h00, 16'h1234, 3'd4);
        chk("num_busy_after", 32'(busy), 32'd0);
        idle(3);
        chk("num_value_held", 32'(value), 32'h1234);
        press("idle_key", 8'h35, S_NONE, 8'h00, 16'h1234, 3'd4);

        // Masked PIN with backspace
        begin_field("pin", 1'b0, 1'b1);
        press("pin_9", 8'h39, S_ECHO, 8'h2A, 16'h0009, 3'd1);
        press("pin_8", 8'h38, S_ECHO, 8'h2A, 16'h0098, 3'd2);
        press("pin_7", 8'h37, S_ECHO, 8'h2A, 16'h0987, 3'd3);
        press("pin_6", 8'h36, S_ECHO, 8'h2A, 16'h9876, 3'd4);
        press("pin_bs", 8'h08, S_NONE, 8'h00, 16'h0987, 3'd3);
        press("pin_5", 8'h35, S_ECHO, 8'h2A, 16'h9875, 3'd4);
        press("pin_enter", 8'h0D, S_DONE, 8'h00, 16'h9875, 3'd4);

        // Too few digits, then overflow digit dropped
        begin_field("min", 1'b0, 1'b0);
        press("min_4", 8'h34, S_ECHO, 8'h34, 16'h0004, 3'd1);
        press("min_2", 8'h32, S_ECHO, 8'h32, 16'h0042, 3'd2);
        press("min_enter_short", 8'h0D, S_REJECT, 8'h00, 16'h0042, 3'd2);
        chk("min_still_busy", 32'(busy), 32'd1);
        press("min_0a", 8'h30, S_ECHO, 8'h30, 16'h0420, 3'd3);
        press("min_0b", 8'h30, S_ECHO, 8'h30, 16'h4200, 3'd4);
        press("min_overflow", 8'h37, S_NONE, 8'h00, 16'h4200, 3'd4);
        press("min_other", 8'h41, S_NONE, 8'h00, 16'h4200, 3'd4);
        press("min_enter", 8'h0D, S_DONE, 8'h00, 16'h4200, 3'd4);

        // Single-key selection
        begin_field("sel", 1'b1, 1'b0);
        press("sel_enter_empty", 8'h0D, S_REJECT, 8'h00, 16'h0000, 3'd0);
        press("sel_3", 8'h33, S_ECHO, 8'h33, 16'h0003, 3'd1);
        press("sel_5", 8'h35, S_ECHO, 8'h35, 16'h0005, 3'd1);
        press("sel_enter", 8'h0D, S_DONE, 8'h00, 16'h0005, 3'd1);

        // Quit, backspace at empty, start+key collision
        begin_field("quit", 1'b0, 1'b0);
        press("quit_bs_empty", 8'h08, S_NONE, 8'h00, 16'h0000, 3'd0);
        press("quit_7", 8'h37, S_ECHO, 8'h37, 16'h0007, 3'd1);
        press("quit_q", 8'h71, S_CANCEL, 8'h00, 16'h0000, 3'd0);
        chk("quit_busy", 32'(busy), 32'd0);
        start = 1'b1;
        key_valid = 1'b1;
        key_code = 8'h31;
        tick();
        start = 1'b0;
        key_valid = 1'b0;
        chk("collide_busy", 32'(busy), 32'd1);
        chk("collide_count", 32'(count), 32'd0);
        press("collide_q", 8'h71, S_CANCEL, 8'h00, 16'h0000, 3'd0);

`ifdef KEYPAD_TIMEOUT_EN
        begin_field("tmo", 1'b0, 1'b0);
        press("tmo_1", 8'h31, S_ECHO, 8'h31, 16'h0001, 3'd1);
        idle(19);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        exp_q.push_back('{tag: "tmo_fire", strobes: S_TMO, echo: 8'h00});
        tick();
        chk("tmo_pending", 32'(exp_q.size()), 32'd0);
        chk("tmo_value", 32'(value), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);

        begin_field("race", 1'b0, 1'b0);
        press("race_1", 8'h31, S_ECHO, 8'h31, 16'h0001, 3'd1);
        idle(19);
        press("race_2", 8'h32, S_ECHO, 8'h32, 16'h0012, 3'd2);
        idle(19);
        chk("race_busy", 32'(busy), 32'd1);
        exp_q.push_back('{tag: "race_fire", strobes: S_TMO, echo: 8'h00});
        tick();
        chk("race_pending", 32'(exp_q.size()), 32'd0);
        chk("race_count", 32'(count), 32'd0);
`else
        begin_field("notmo", 1'b0, 1'b0);
        press("notmo_1", 8'h31, S_ECHO, 8'h31, 16'h0001, 3'd1);
        idle(25);
        chk("notmo_busy", 32'(busy), 32'd1);
        press("notmo_q", 8'h71, S_CANCEL, 8'h00, 16'h0000, 3'd0);
`endif

        // Asynchronous reset mid-field
        begin_field("rst", 1'b0, 1'b0);
        press("rst_3", 8'h33, S_ECHO, 8'h33, 16'h0003, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        idle(2);
        chk("rst_busy_after", 32'(busy), 32'd0);
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_field_capture.md
# keypad_field_capture

Parametrised successor to the single-purpose ASCII entry logic. It collects a multi-digit decimal field (account number, PIN, amount) or a single-key selection (menu, currency) from the decoded keyboard ASCII stream. Editing is in-field: backspace, enter, quit and an inactivity timeout are all handled inside the block. The result is a packed BCD value with a one-cycle completion strobe, so the ATM control FSM consumes the field without per-field glue.

## Interface
Parameters:
- DIGITS, 4, maximum digits stored (1..8)
- MIN_DIGITS, 4, minimum digits for enter to be accepted (1..DIGITS)
- TIMEOUT_CYCLES, 300000000, inactivity limit in clk cycles (3 s at 100 MHz)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; arms a new field capture
- mode  in  1  0 = NUMERIC field, 1 = SELECT single key
- mask  in  1  1 = echo '*' instead of digit (PIN entry)
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  8  ASCII code
- value  out  4*DIGITS  BCD; first-typed digit is most significant, right-aligned
- count  out  $clog2(DIGITS+1)  digits currently held
- busy  out  1  high while capturing
- done  out  1  one-cycle pulse; field accepted
- reject  out  1  one-cycle pulse; enter pressed with too few digits
- cancel  out  1  one-cycle pulse; 'q' pressed
- timeout  out  1  one-cycle pulse; inactivity limit reached
- echo_valid  out  1  one-cycle pulse per accepted digit
- echo_code  out  8  ASCII to display

## Operation
- States: IDLE, COLLECT.
- IDLE:
  - start → COLLECT; clears value and count; latches mode and mask.
  - Keys are ignored.
- COLLECT, one key per key_valid:
  - 0x30–0x39, NUMERIC:
    - If count < DIGITS: value <= {value[4*DIGITS-5:0], digit}, count+1, echo pulse.
    - If count == DIGITS: the digit is dropped; no echo.
  - 0x30–0x39, SELECT: value <= digit (low nibble), count = 1, echo pulse; a later digit overwrites.
  - 0x08 backspace, count > 0: value <= value >> 4, count−1. Ignored at count 0.
  - 0x0D enter:
    - count >= MIN_DIGITS (SELECT mode: count == 1) → done, IDLE, value held.
    - Otherwise → reject, remain in COLLECT.
  - 0x71 'q' → cancel, IDLE, value and count cleared.
  - All other codes ignored; they still reset the inactivity timer.
- start during COLLECT is ignored.
- echo_code = mask ? 0x2A : key_code.

## Timing
- All outputs are registered. A key sampled at edge N is reflected on value, count and the strobes after edge N; strobes are high for exactly that one cycle.
- value and count are stable from done until the next start.
- Reset values: every output 0; state IDLE; timer 0.
- start and key_valid in the same IDLE cycle: start wins, the key is dropped.
- Timer:
  - Clears on start and on every key_valid in COLLECT.
  - Reaching TIMEOUT_CYCLES−1 with no key → timeout pulse, value and count cleared, IDLE.
  - key_valid in the expiry cycle: the key wins and no timeout fires.
- rst_n asserted mid-capture: immediate return to IDLE, all outputs 0, no strobe emitted.

## Configuration
- KEYPAD_TIMEOUT_EN defined: inactivity timer present as above.
- KEYPAD_TIMEOUT_EN undefined: no timer logic; timeout tied 0; COLLECT persists until enter or 'q'.

## Structure
- Shared package atm_pkg:
  - key code constants: KEY_ENTER 0x0D, KEY_BS 0x08, KEY_QUIT 0x71, KEY_MASK 0x2A, KEY_0 0x30.
  - mode encodings FIELD_NUMERIC and FIELD_SELECT.
  - CLOCK_FREQ constant.
- Sub-module inactivity_timer (clear, enable, expire pulse; width derived from TIMEOUT_CYCLES), instantiated only under KEYPAD_TIMEOUT_EN.

## Test plan
- NUMERIC, DIGITS=4: start, keys '1','2','3','4', enter → done pulse, value 0x1234, count 4; echo_code 0x31..0x34.
- mask=1: keys '9','8','7','6', backspace, '5', enter → value 0x9875; each echo_code 0x2A.
- MIN_DIGITS=4: keys '4','2', enter → reject pulse, state COLLECT; then '0','0', enter → value 0x4200. A fifth digit key at count 4 is dropped.
- SELECT: start, keys '3','5', enter → done, value 0x0005, count 1. Enter with no digit → reject.
- 'q' after '7' → cancel pulse, value 0, busy 0. start and key '1' in the same cycle → count 0.
- KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=20: start, '1', then idle 20 cycles → timeout pulse and value 0. Key in the expiry cycle → no timeout. rst_n low mid-field → all outputs 0.
